// File: rtl/ofdm_symbol_sched_pkg.sv
// Shared types and constants for the OFDM symbol scheduler.
// Slot type codes, FSM states and default subcarrier maps.
package ofdm_symbol_sched_pkg;

  localparam logic [1:0] SC_TYPE_DATA  = 2'b00;
  localparam logic [1:0] SC_TYPE_PILOT = 2'b01;
  localparam logic [1:0] SC_TYPE_NULL  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_KICK,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [15:0] DEF_PILOT_MASK = 16'h0810;
  localparam logic [15:0] DEF_NULL_MASK  = 16'h8001;
  localparam logic [3:0]  DEF_PILOT_VAL  = 4'b0101;

  // Symbol counter width; a single-symbol frame still gets one bit.
  function automatic int sym_w(input int syms);
    return (syms > 1) ? $clog2(syms) : 1;
  endfunction

endpackage

// File: rtl/ofdm_symbol_sched_slot_decode.sv
// Per-slot classification of the subcarrier map.
// Null wins over pilot; pilot word flips on odd symbols.
module ofdm_slot_decode
  import ofdm_symbol_sched_pkg::*;
#(
  parameter int NSC = 16,
  parameter int DW  = 4,
  parameter logic [NSC-1:0] PILOT_MASK = NSC'(DEF_PILOT_MASK),
  parameter logic [NSC-1:0] NULL_MASK  = NSC'(DEF_NULL_MASK),
  parameter logic [DW-1:0]  PILOT_VAL  = DW'(DEF_PILOT_VAL),
  localparam int KW = $clog2(NSC)
) (
  input  logic [KW-1:0] i_k,
  input  logic          i_odd,
  output logic          o_is_null,
  output logic          o_is_pilot,
  output logic [DW-1:0] o_pilot_word
);

  // Pure lookup on the slot index and symbol parity
  always_comb begin
    o_is_null    = NULL_MASK[i_k];
    o_is_pilot   = PILOT_MASK[i_k] & ~NULL_MASK[i_k];
    o_pilot_word = PILOT_VAL ^ {DW{i_odd}};
  end

endmodule

// File: rtl/ofdm_symbol_sched.sv
// OFDM symbol scheduler: fills the IFFT input buffer slot by
// slot, kicks the IFFT and repeats for every symbol of a frame.
module ofdm_symbol_sched
  import ofdm_symbol_sched_pkg::*;
#(
  parameter int NSC  = 16,
  parameter int DW   = 4,
  parameter int SYMS = 8,
  parameter logic [NSC-1:0] PILOT_MASK = NSC'(DEF_PILOT_MASK),
  parameter logic [NSC-1:0] NULL_MASK  = NSC'(DEF_NULL_MASK),
  parameter logic [DW-1:0]  PILOT_VAL  = DW'(DEF_PILOT_VAL),
  localparam int KW = $clog2(NSC),
  localparam int SW = sym_w(SYMS)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [DW-1:0] i_din,
  input  logic          i_din_valid,
  output logic          o_din_ready,
  output logic          o_sc_we,
  output logic [KW-1:0] o_sc_idx,
  output logic [DW-1:0] o_sc_data,
  output logic [1:0]    o_sc_type,
  output logic          o_ifft_start,
  input  logic          i_ifft_done,
  output logic          o_busy,
  output logic [SW-1:0] o_sym_cnt,
  output logic          o_frame_done
);

  state_t        r_state;
  logic [KW-1:0] r_k;
  logic [SW-1:0] r_sym;
  logic          r_we;
  logic [KW-1:0] r_idx;
  logic [DW-1:0] r_data;
  logic [1:0]    r_type;
  logic          r_ifft;
  logic          r_busy;
  logic          r_fd;

  state_t        w_state_n;
  logic [KW-1:0] w_k_n;
  logic [SW-1:0] w_sym_n;
  logic          w_we_n;
  logic [KW-1:0] w_idx_n;
  logic [DW-1:0] w_data_n;
  logic [1:0]    w_type_n;
  logic          w_ifft_n;
  logic          w_busy_n;
  logic          w_fd_n;
  logic          w_rdy;
  logic          w_take;

  logic          w_is_null;
  logic          w_is_pilot;
  logic [DW-1:0] w_pilot_word;

  ofdm_slot_decode #(
    .NSC        (NSC),
    .DW         (DW),
    .PILOT_MASK (PILOT_MASK),
    .NULL_MASK  (NULL_MASK),
    .PILOT_VAL  (PILOT_VAL)
  ) u_dec (
    .i_k          (r_k),
    .i_odd        (r_sym[0]),
    .o_is_null    (w_is_null),
    .o_is_pilot   (w_is_pilot),
    .o_pilot_word (w_pilot_word)
  );

  // Next-state and next-output decision for the frame sequencer
  always_comb begin
    w_state_n = r_state;
    w_k_n     = r_k;
    w_sym_n   = r_sym;
    w_we_n    = 1'b0;
    w_idx_n   = r_idx;
    w_data_n  = r_data;
    w_type_n  = r_type;
    w_ifft_n  = 1'b0;
    w_busy_n  = r_busy;
    w_fd_n    = 1'b0;
    w_rdy     = 1'b0;
    w_take    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_n = ST_FILL;
          w_k_n     = '0;
          w_sym_n   = '0;
          w_busy_n  = 1'b1;
        end
      end
      ST_FILL: begin
        w_rdy  = ~w_is_null & ~w_is_pilot;
        w_take = ~w_rdy | i_din_valid;
        if (w_take) begin
          w_we_n  = 1'b1;
          w_idx_n = r_k;
          unique case (1'b1)
            w_is_null: begin
              w_data_n = '0;
              w_type_n = SC_TYPE_NULL;
            end
            w_is_pilot: begin
              w_data_n = w_pilot_word;
              w_type_n = SC_TYPE_PILOT;
            end
            default: begin
              w_data_n = i_din;
              w_type_n = SC_TYPE_DATA;
            end
          endcase
          if (r_k == KW'(NSC - 1)) begin
            w_state_n = ST_KICK;
            w_k_n     = '0;
            w_ifft_n  = 1'b1;
          end else begin
            w_k_n = r_k + 1'b1;
          end
        end
      end
      ST_KICK: begin
        w_state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_ifft_done) begin
          if (r_sym == SW'(SYMS - 1)) begin
            w_state_n = ST_DONE;
            w_fd_n    = 1'b1;
          end else begin
            w_state_n = ST_FILL;
            w_sym_n   = r_sym + 1'b1;
            w_k_n     = '0;
          end
        end
      end
      ST_DONE: begin
        w_state_n = ST_IDLE;
        w_busy_n  = 1'b0;
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_sym   <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      r_type  <= '0;
      r_ifft  <= 1'b0;
      r_busy  <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_k     <= w_k_n;
      r_sym   <= w_sym_n;
      r_we    <= w_we_n;
      r_idx   <= w_idx_n;
      r_data  <= w_data_n;
      r_type  <= w_type_n;
      r_ifft  <= w_ifft_n;
      r_busy  <= w_busy_n;
      r_fd    <= w_fd_n;
    end
  end

  assign o_din_ready  = w_rdy & ~i_reset;
  assign o_sc_we      = r_we;
  assign o_sc_idx     = r_idx;
  assign o_sc_data    = r_data;
  assign o_sc_type    = r_type;
  assign o_ifft_start = r_ifft;
  assign o_busy       = r_busy;
  assign o_sym_cnt    = r_sym;
  assign o_frame_done = r_fd;

endmodule

// File: tb/tb_ofdm_symbol_sched.sv
// Bench for ofdm_symbol_sched: default map instance plus a
// single-symbol all-data instance, checked by a slot scoreboard.
module tb_ofdm_symbol_sched;

  localparam int LIM = 4000;

  logic       clk;
  logic       rst   [2];
  logic       start [2];
  logic [3:0] din   [2];
  logic       vld   [2];
  logic       done  [2];
  logic       rdy   [2];
  logic       we    [2];
  logic [3:0] idx   [2];
  logic [3:0] data  [2];
  logic [1:0] typ   [2];
  logic       ist   [2];
  logic       busy  [2];
  logic       fd    [2];
  logic [2:0] sym0;
  logic [0:0] sym1;

  int n_tests = 0;
  int n_fail  = 0;

  int vmode = 0;
  int spur  = 0;
  int dly   = 3;

  ofdm_symbol_sched u_dut0 (
    .i_clk(clk), .i_reset(rst[0]), .i_start(start[0]),
    .i_din(din[0]), .i_din_valid(vld[0]), .o_din_ready(rdy[0]),
    .o_sc_we(we[0]), .o_sc_idx(idx[0]), .o_sc_data(data[0]),
    .o_sc_type(typ[0]), .o_ifft_start(ist[0]),
    .i_ifft_done(done[0]), .o_busy(busy[0]),
    .o_sym_cnt(sym0), .o_frame_done(fd[0])
  );

  ofdm_symbol_sched #(
    .SYMS(1), .PILOT_MASK(16'h0000), .NULL_MASK(16'h0000)
  ) u_dut1 (
    .i_clk(clk), .i_reset(rst[1]), .i_start(start[1]),
    .i_din(din[1]), .i_din_valid(vld[1]), .o_din_ready(rdy[1]),
    .o_sc_we(we[1]), .o_sc_idx(idx[1]), .o_sc_data(data[1]),
    .o_sc_type(typ[1]), .o_ifft_start(ist[1]),
    .i_ifft_done(done[1]), .o_busy(busy[1]),
    .o_sym_cnt(sym1), .o_frame_done(fd[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, d, act, exp);
    end
  endtask

  function automatic int symv(input int d);
    return (d == 0) ? int'(sym0) : int'(sym1);
  endfunction

  // Spec-level slot map of each instance
  function automatic void slot_exp(input int d, input int k, input int s,
                                   output logic [1:0] t,
                                   output logic [3:0] v,
                                   output bit isd);
    logic [15:0] pm;
    logic [15:0] nm;
    pm  = (d == 0) ? 16'h0810 : 16'h0000;
    nm  = (d == 0) ? 16'h8001 : 16'h0000;
    isd = 1'b0;
    if (nm[k]) begin
      t = 2'b10; v = 4'h0;
    end else if (pm[k]) begin
      t = 2'b01; v = (s % 2 == 1) ? 4'b1010 : 4'b0101;
    end else begin
      t = 2'b00; v = 4'h0; isd = 1'b1;
    end
  endfunction

  logic [3:0] q0[$];
  logic [3:0] q1[$];

  function automatic void qpush(input int d, input logic [3:0] v);
    if (d == 0) q0.push_back(v);
    else q1.push_back(v);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [3:0] qpop(input int d);
    logic [3:0] v;
    if (d == 0) v = q0.pop_front();
    else v = q1.pop_front();
    return v;
  endfunction

  function automatic void qclr(input int d);
    if (d == 0) q0.delete();
    else q1.delete();
  endfunction

  bit m_run   [2] = '{0, 0};
  bit m_wait  [2] = '{0, 0};
  bit m_prst  [2] = '{0, 0};
  bit m_efd   [2] = '{0, 0};
  bit m_ebusy [2] = '{0, 0};
  int m_k     [2] = '{0, 0};
  int m_sym   [2] = '{0, 0};
  int n_ist   [2] = '{0, 0};
  int n_fd    [2] = '{0, 0};
  int n_acc   [2] = '{0, 0};
  int n_we    [2] = '{0, 0};

  // Scoreboard: every write is matched against the slot map,
  // with data slots drawing accepted nibbles in order.
  always @(negedge clk) begin
    logic [1:0] et;
    logic [3:0] ev;
    bit isd;
    bit lastw;
    bit was_run;
    int ns;
    for (int d = 0; d < 2; d++) begin
      ns = (d == 0) ? 8 : 1;
      if (m_prst[d]) begin
        chk("rst_we", d, we[d], 0);
        chk("rst_ist", d, ist[d], 0);
        chk("rst_busy", d, busy[d], 0);
        chk("rst_fd", d, fd[d], 0);
        chk("rst_idx", d, idx[d], 0);
        chk("rst_data", d, data[d], 0);
        chk("rst_type", d, typ[d], 0);
        chk("rst_sym", d, symv(d), 0);
        m_run[d] = 0; m_wait[d] = 0; m_efd[d] = 0;
        m_ebusy[d] = 0; m_k[d] = 0; m_sym[d] = 0;
        qclr(d);
      end else begin
        was_run = m_run[d];
        chk("busy", d, busy[d], m_ebusy[d]);
        if (fd[d] || m_efd[d]) chk("frame_done", d, fd[d], m_efd[d]);
        if (fd[d]) n_fd[d]++;
        if (m_efd[d]) m_run[d] = 0;
        m_efd[d] = 0;
        lastw = 0;
        if (we[d]) begin
          n_we[d]++;
          chk("we_in_frame", d, was_run, 1);
          slot_exp(d, m_k[d], m_sym[d], et, ev, isd);
          if (isd) begin
            if (qsize(d) == 0) chk("din_avail", d, 0, 1);
            else ev = qpop(d);
          end
          chk("sc_idx", d, idx[d], m_k[d]);
          chk("sc_type", d, typ[d], et);
          chk("sc_data", d, data[d], ev);
          chk("sym_cnt", d, symv(d), m_sym[d]);
          m_k[d]++;
          if (m_k[d] == 16) begin
            m_k[d] = 0;
            lastw = 1;
            chk("din_per_sym", d, qsize(d), 0);
          end
        end
        if (ist[d] || lastw) chk("ifft_start", d, ist[d], lastw);
        if (ist[d]) n_ist[d]++;
        if (m_wait[d] && done[d]) begin
          m_wait[d] = 0;
          if (m_sym[d] == ns - 1) m_efd[d] = 1;
          else m_sym[d]++;
        end
        if (ist[d]) m_wait[d] = 1;
        if (!was_run && start[d] && !rst[d]) begin
          m_run[d] = 1; m_k[d] = 0; m_sym[d] = 0;
        end
        m_ebusy[d] = m_run[d];
      end
      if (rst[d]) begin
        chk("rdy_in_reset", d, rdy[d], 0);
      end else if (vld[d] && rdy[d]) begin
        qpush(d, din[d]);
        n_acc[d]++;
      end
      m_prst[d] = rst[d];
    end
  end

  // Upstream source and IFFT completion emulation
  initial begin : drv
    bit acc [2];
    int cnt [2];
    cnt[0] = 0; cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        acc[d] = vld[d] && rdy[d];
        if (ist[d]) cnt[d] = (dly == 0) ? 1 + int'($urandom % 5) : dly;
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (acc[d]) din[d] = (vmode == 2) ? 4'($urandom) : din[d] + 4'd1;
        case (vmode)
          0: vld[d] = 1'b1;
          1: vld[d] = ~vld[d];
          default: vld[d] = 1'($urandom % 2);
        endcase
        done[d] = 1'b0;
        if (cnt[d] > 0) begin
          cnt[d]--;
          if (cnt[d] == 0) done[d] = 1'b1;
        end
        if (spur != 0 && ($urandom % 4 == 0)) done[d] = 1'b1;
      end
    end
  end

  typedef struct {
    int d;
    int vm;
    int sp;
    int dl;
    int spam;
    int e_ist;
    int e_fd;
    int e_acc;
  } vec_t;

  vec_t tbl[6];

  task automatic run_frame(input vec_t v);
    int i0, f0, a0, w0, cyc;
    vmode = v.vm; spur = v.sp; dly = v.dl;
    i0 = n_ist[v.d]; f0 = n_fd[v.d];
    a0 = n_acc[v.d]; w0 = n_we[v.d];
    @(posedge clk); #1 start[v.d] = 1'b1;
    @(posedge clk); #1 start[v.d] = 1'b0;
    cyc = 0;
    while (n_fd[v.d] == f0 && cyc < LIM) begin
      @(posedge clk); #1;
      cyc++;
      start[v.d] = (v.spam != 0) && busy[v.d] && ($urandom % 3 == 0);
    end
    start[v.d] = 1'b0;
    spur = 0;
    chk("frame_timeout", v.d, cyc < LIM, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("n_ifft_start", v.d, n_ist[v.d] - i0, v.e_ist);
    chk("n_frame_done", v.d, n_fd[v.d] - f0, v.e_fd);
    chk("n_din_acc", v.d, n_acc[v.d] - a0, v.e_acc);
    chk("n_sc_we", v.d, n_we[v.d] - w0, 16 * v.e_ist);
    chk("idle_busy", v.d, busy[v.d], 0);
  endtask

  initial begin : main
    int cyc, i0;
    tbl[0] = '{0, 0, 0, 3, 0, 8, 1, 96};
    tbl[1] = '{0, 1, 0, 3, 0, 8, 1, 96};
    tbl[2] = '{0, 2, 1, 0, 0, 8, 1, 96};
    tbl[3] = '{0, 2, 0, 2, 1, 8, 1, 96};
    tbl[4] = '{1, 0, 0, 3, 0, 1, 1, 16};
    tbl[5] = '{1, 1, 1, 0, 0, 1, 1, 16};
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; din[d] = 4'h0;
      vld[d] = 1'b0; done[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    // Reset in the middle of symbol 3, around slot 7
    vmode = 0; spur = 0; dly = 3;
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!(we[0] && idx[0] == 4'd7 && sym0 == 3'd3) && cyc < LIM) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reach", 0, cyc < LIM, 1);
    @(posedge clk); #1 rst[0] = 1'b1;
    @(posedge clk); #1 rst[0] = 1'b0;
    i0 = n_we[0];
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_we", 0, n_we[0] - i0, 0);
    chk("post_rst_busy", 0, busy[0], 0);
    run_frame(tbl[0]);

    // Start together with reset must not begin a frame
    @(posedge clk); #1;
    rst[0] = 1'b1; start[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0; start[0] = 1'b0;
    i0 = n_we[0];
    repeat (4) @(posedge clk);
    #1;
    chk("start_in_rst_busy", 0, busy[0], 0);
    chk("start_in_rst_we", 0, n_we[0] - i0, 0);
    run_frame(tbl[4]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
